// File: rtl/bin_to_bcd_serial_pkg.sv
// rtl/bin_to_bcd_serial_pkg.sv - shared state encoding and default sizes for the serial BCD converter
package bin_to_bcd_serial_pkg;

  localparam int DEF_IN_W   = 8;
  localparam int DEF_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_bcd_serial_add3.sv
// rtl/bin_to_bcd_serial_add3.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// rtl/bin_to_bcd_serial.sv - serial double-dabble binary to packed BCD converter, one bit per cycle
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t            state;
  logic [IN_W-1:0]   sh;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  scratch_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_s;
  logic              carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit is a carry worth 10^DIGITS; dropping it leaves the value mod 10^DIGITS.
  assign carry       = adj[BCD_W-1];
  assign scratch_nxt = {adj[BCD_W-2:0], sh[IN_W-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
      scratch  <= '0;
      sh       <= '0;
      ovf_s    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh      <= bin_in;
            scratch <= '0;
            ovf_s   <= 1'b0;
            cnt     <= CNT_W'(IN_W);
            state   <= SHIFT;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          sh      <= sh << 1;
          cnt     <= cnt - CNT_W'(1);
          ovf_s   <= ovf_s | carry;
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            done     <= 1'b1;
            bcd_out  <= scratch_nxt;
            overflow <= ovf_s | carry;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// tb/tb_bin_to_bcd_serial.sv - directed scoreboard bench for bin_to_bcd_serial (default and 10-bit builds)
module tb_bin_to_bcd_serial;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  bin_a = '0;
  logic [9:0]  bin_b = '0;
  logic        ready_a, busy_a, done_a, ovf_a;
  logic        ready_b, busy_b, done_b, ovf_b;
  logic [11:0] bcd_a, bcd_b;

  int checks = 0;
  int failures = 0;
  logic [12:0] q_a[$];
  logic [12:0] q_b[$];

  always #5 clk = ~clk;

  bin_to_bcd_serial dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .bin_in(bin_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_serial #(.IN_W(10), .DIGITS(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bin_in(bin_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit sel, input string tag, output int cyc);
    logic [12:0] e;
    cyc = 0;
    while (!(sel ? done_b : done_a) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 60), 32'd1);
    if (cyc < 60) begin
      if ((sel ? q_b.size() : q_a.size()) == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sel ? q_b.pop_front() : q_a.pop_front();
        check({tag, "_bcd"}, 32'(sel ? bcd_b : bcd_a), 32'(e[11:0]));
        check({tag, "_ovf"}, 32'(sel ? ovf_b : ovf_a), 32'(e[12]));
      end
    end
  endtask

  task automatic run_conv(input bit sel, input logic [9:0] val, input logic [11:0] exp_bcd,
                          input logic exp_ovf, input string tag);
    int cyc;
    if (sel) q_b.push_back({exp_ovf, exp_bcd});
    else     q_a.push_back({exp_ovf, exp_bcd});
    @(negedge clk);
    if (sel) begin start_b = 1'b1; bin_b = val; end
    else     begin start_a = 1'b1; bin_a = val[7:0]; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, "_busy"}, 32'(sel ? {ready_b, busy_b} : {ready_a, busy_a}), 32'b01);
    wait_done(sel, tag, cyc);
    check({tag, "_latency"}, 32'(cyc), sel ? 32'd10 : 32'd8);
    @(negedge clk);
    check({tag, "_idle"}, 32'(sel ? {ready_b, busy_b, done_b} : {ready_a, busy_a, done_a}), 32'b100);
  endtask

  initial begin
    int cyc;
    int n;
    int t_prev;
    int t_now;
    logic [11:0] walk_exp [8];
    walk_exp = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h016, 12'h032, 12'h064, 12'h128};

    repeat (2) @(negedge clk);
    check("rst_ctrl", {29'd0, ready_a, busy_a, done_a}, 32'b100);
    check("rst_data", {19'd0, ovf_a, bcd_a}, 32'd0);
    reset_n = 1'b1;

    run_conv(1'b0, 10'd0, 12'h000, 1'b0, "zero");
    for (int i = 0; i < 8; i++) begin
      run_conv(1'b0, 10'(1 << i), walk_exp[i], 1'b0, $sformatf("walk%0d", i));
    end

    // Second start three cycles into the conversion must be ignored entirely.
    q_a.push_back({1'b0, 12'h255});
    @(negedge clk); start_a = 1'b1; bin_a = 8'd255;
    @(negedge clk); start_a = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1; bin_a = 8'd7;
    @(negedge clk); start_a = 1'b0;
    wait_done(1'b0, "ign", cyc);
    n = 0;
    repeat (20) begin @(negedge clk); if (done_a) n++; end
    check("ign_extra_done", 32'(n), 32'd0);

    run_conv(1'b1, 10'd1023, 12'h023, 1'b1, "w10_1023");
    run_conv(1'b1, 10'd999, 12'h999, 1'b0, "w10_999");

    // Abort mid-conversion with reset.
    @(negedge clk); start_a = 1'b1; bin_a = 8'd200;
    @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ctrl", {29'd0, ready_a, busy_a, done_a}, 32'b100);
    check("abort_data", {19'd0, ovf_a, bcd_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (12) begin @(negedge clk); if (done_a) n++; end
    check("abort_no_done", 32'(n), 32'd0);
    run_conv(1'b0, 10'd99, 12'h099, 1'b0, "after_abort");

    // Continuous start: three back-to-back conversions, one every IN_W+2 cycles.
    for (int i = 0; i < 3; i++) q_a.push_back({1'b0, 12'h042});
    @(negedge clk); start_a = 1'b1; bin_a = 8'd42;
    t_prev = 0;
    t_now = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); t_now++;
      wait_done(1'b0, $sformatf("b2b%0d", i), cyc);
      t_now += cyc;
      if (i > 0) check($sformatf("b2b_period%0d", i), 32'(t_now - t_prev), 32'd10);
      t_prev = t_now;
    end
    start_a = 1'b0;
    n = 0;
    repeat (15) begin @(negedge clk); if (done_a) n++; end
    check("b2b_stop", 32'(n), 32'd0);
    check("sb_drained", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
